// File: rtl/ble_rx_dma.sv
// ble_rx_dma: buffers UART RX bytes in a FIFO and writes them into a RAM ring,
// sharing the single RAM Wishbone port with the CPU (CPU has priority from IDLE).
module ble_rx_dma #(
    parameter int          BITS       = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] ADR_LL     = 32'h00C00000,
    parameter logic [31:0] ADR_UL     = 32'h00C10000
) (
    input  logic                          i_wb_clk,
    input  logic                          i_wb_rst,
    input  logic [BITS-1:0]               i_rx_dat,
    input  logic                          i_rx_done,
    input  logic                          i_clr_ovf,
    input  logic [31:0]                   i_wb_cpu_adr,
    input  logic [31:0]                   i_wb_cpu_dat,
    input  logic [3:0]                    i_wb_cpu_sel,
    input  logic                          i_wb_cpu_we,
    input  logic                          i_wb_cpu_cyc,
    output logic [31:0]                   o_wb_cpu_rdt,
    output logic                          o_wb_cpu_ack,
    output logic [31:0]                   o_wb_mem_adr,
    output logic [31:0]                   o_wb_mem_dat,
    output logic [3:0]                    o_wb_mem_sel,
    output logic                          o_wb_mem_we,
    output logic                          o_wb_mem_cyc,
    input  logic [31:0]                   i_wb_mem_rdt,
    input  logic                          i_wb_mem_ack,
    output logic [31:0]                   o_wr_ptr,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;

    state_t              state_q, state_d;
    logic [BITS-1:0]     fifo_q [FIFO_DEPTH];
    logic [AW-1:0]       rd_q, wr_q;
    logic [AW:0]         count_q, count_d;
    logic [31:0]         ptr_q, ptr_d;
    logic                ovf_q, ovf_d;
    logic                pop, push;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop     = state_q == DMA && i_wb_mem_ack;
    assign push    = i_rx_done && (count_q < (AW+1)'(FIFO_DEPTH) || pop);
    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign ptr_d   = pop ? (ptr_q == ADR_UL - 32'd1 ? ADR_LL : ptr_q + 32'd1) : ptr_q;
    assign ovf_d   = (i_rx_done && !push) || (ovf_q && !i_clr_ovf);

    assign o_wb_cpu_rdt = i_wb_mem_rdt;
    assign o_wr_ptr     = ptr_q;
    assign o_count      = count_q;
    assign o_overflow   = ovf_q;

    always_comb begin
        state_d      = state_q;
        o_wb_mem_adr = '0;
        o_wb_mem_dat = '0;
        o_wb_mem_sel = '0;
        o_wb_mem_we  = 1'b0;
        o_wb_mem_cyc = 1'b0;
        o_wb_cpu_ack = 1'b0;
        unique case (state_q)
            IDLE: state_d = i_wb_cpu_cyc ? CPU : (count_q != '0 ? DMA : IDLE);
            CPU: begin
                o_wb_mem_adr = i_wb_cpu_adr;
                o_wb_mem_dat = i_wb_cpu_dat;
                o_wb_mem_sel = i_wb_cpu_sel;
                o_wb_mem_we  = i_wb_cpu_we;
                o_wb_mem_cyc = i_wb_cpu_cyc;
                o_wb_cpu_ack = i_wb_mem_ack;
                state_d      = i_wb_mem_ack ? IDLE : CPU;
            end
            DMA: begin
                o_wb_mem_adr = ptr_q;
                o_wb_mem_dat = {4{fifo_q[rd_q]}};
                o_wb_mem_sel = 4'b0001 << ptr_q[1:0];
                o_wb_mem_we  = 1'b1;
                o_wb_mem_cyc = 1'b1;
                state_d      = i_wb_mem_ack ? IDLE : DMA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (push)
            fifo_q[wr_q] <= i_rx_dat;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ptr_q   <= ADR_LL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_q + AW'(pop);
            wr_q    <= wr_q + AW'(push);
            count_q <= count_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_ble_rx_dma.sv
// tb_ble_rx_dma: two DUTs (full ring and a 4-byte ring) on shared stimulus,
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_ble_rx_dma;
    localparam logic [31:0] LL  = 32'h00C00000;
    localparam logic [31:0] UL0 = 32'h00C10000;
    localparam logic [31:0] UL1 = 32'h00C00004;
    localparam int DEPTH = 8;
    typedef logic [7:0] bq_t[$];

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [7:0]  rx_dat = 0;
    logic        rx_done = 0, clr_ovf = 0;
    logic [31:0] cpu_adr = 0, cpu_dat = 0;
    logic [3:0]  cpu_sel = 0;
    logic        cpu_we = 0, cpu_cyc = 0;

    logic [31:0] c_rdt0, m_adr0, m_dat0, ptr0, rdt0, c_rdt1, m_adr1, m_dat1, ptr1, rdt1;
    logic [3:0]  m_sel0, m_sel1, cnt0, cnt1;
    logic        c_ack0, m_we0, m_cyc0, ovf0, ack0, c_ack1, m_we1, m_cyc1, ovf1, ack1;

    ble_rx_dma #(.FIFO_DEPTH(DEPTH), .ADR_LL(LL), .ADR_UL(UL0)) dut0 (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_rx_dat(rx_dat), .i_rx_done(rx_done),
        .i_clr_ovf(clr_ovf), .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat),
        .i_wb_cpu_sel(cpu_sel), .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
        .o_wb_cpu_rdt(c_rdt0), .o_wb_cpu_ack(c_ack0), .o_wb_mem_adr(m_adr0),
        .o_wb_mem_dat(m_dat0), .o_wb_mem_sel(m_sel0), .o_wb_mem_we(m_we0),
        .o_wb_mem_cyc(m_cyc0), .i_wb_mem_rdt(rdt0), .i_wb_mem_ack(ack0),
        .o_wr_ptr(ptr0), .o_count(cnt0), .o_overflow(ovf0));

    ble_rx_dma #(.FIFO_DEPTH(DEPTH), .ADR_LL(LL), .ADR_UL(UL1)) dut1 (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_rx_dat(rx_dat), .i_rx_done(rx_done),
        .i_clr_ovf(clr_ovf), .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat),
        .i_wb_cpu_sel(cpu_sel), .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
        .o_wb_cpu_rdt(c_rdt1), .o_wb_cpu_ack(c_ack1), .o_wb_mem_adr(m_adr1),
        .o_wb_mem_dat(m_dat1), .o_wb_mem_sel(m_sel1), .o_wb_mem_we(m_we1),
        .o_wb_mem_cyc(m_cyc1), .i_wb_mem_rdt(rdt1), .i_wb_mem_ack(ack1),
        .o_wr_ptr(ptr1), .o_count(cnt1), .o_overflow(ovf1));

    // RAM stand-ins: ack one cycle after cyc, read data derived from the address
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0 <= 0; ack1 <= 0; rdt0 <= 0; rdt1 <= 0;
        end else begin
            ack0 <= m_cyc0 && !ack0;
            ack1 <= m_cyc1 && !ack1;
            rdt0 <= m_adr0 ^ 32'hDEADBEEF;
            rdt1 <= m_adr1 ^ 32'hDEADBEEF;
        end
    end

    int n_pass = 0, n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // owner: 0 none, 1 cpu, 2 dma
    bq_t mq0, mq1;
    logic [31:0] mp0 = LL, mp1 = LL;
    logic mo0 = 0, mo1 = 0;
    int own0 = 0, own1 = 0;

    task automatic mstep(inout bq_t q, inout logic [31:0] p, inout logic ov, inout int own,
                         input logic [31:0] lim, input logic ack);
        int n = q.size();
        bit pop = own == 2 && ack;
        bit drop = rx_done && !(n < DEPTH || pop);
        if (own == 0) own = cpu_cyc ? 1 : (n > 0 ? 2 : 0);
        else if (ack) own = 0;
        if (pop) begin
            q.delete(0);
            p = (p == lim - 1) ? LL : p + 1;
        end
        if (rx_done && !drop) q.push_back(rx_dat);
        ov = drop ? 1'b1 : (clr_ovf ? 1'b0 : ov);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq0 = {}; mq1 = {}; mp0 = LL; mp1 = LL; mo0 = 0; mo1 = 0; own0 = 0; own1 = 0;
        end else begin
            mstep(mq0, mp0, mo0, own0, UL0, ack0);
            mstep(mq1, mp1, mo1, own1, UL1, ack1);
        end
    end

    task automatic cmp(input string t, input bq_t q, input logic [31:0] p, input logic ov, input int own,
                       input logic [31:0] adr, dat, input logic [3:0] sel, input logic we, cyc,
                       input logic cack, input logic [31:0] crdt, mrdt, input logic mack,
                       input logic [31:0] ptr, input logic [3:0] cnt, input logic ovf);
        logic [7:0] h = q.size() > 0 ? q[0] : 8'h0;
        chk({t, "_cyc"}, cyc, own != 0);
        chk({t, "_we"},  we,  own == 1 ? cpu_we : own == 2);
        chk({t, "_adr"}, adr, own == 1 ? cpu_adr : (own == 2 ? p : 0));
        chk({t, "_sel"}, sel, own == 1 ? cpu_sel : (own == 2 ? 4'b0001 << p[1:0] : 4'h0));
        chk({t, "_dat"}, dat, own == 1 ? cpu_dat : (own == 2 ? {4{h}} : 0));
        chk({t, "_cack"}, cack, own == 1 ? mack : 1'b0);
        chk({t, "_rdt"}, crdt, mrdt);
        chk({t, "_ptr"}, ptr, p);
        chk({t, "_cnt"}, cnt, q.size());
        chk({t, "_ovf"}, ovf, ov);
    endtask

    always @(negedge clk) begin
        cmp("d0", mq0, mp0, mo0, own0, m_adr0, m_dat0, m_sel0, m_we0, m_cyc0, c_ack0, c_rdt0, rdt0, ack0, ptr0, cnt0, ovf0);
        cmp("d1", mq1, mp1, mo1, own1, m_adr1, m_dat1, m_sel1, m_we1, m_cyc1, c_ack1, c_rdt1, rdt1, ack1, ptr1, cnt1, ovf1);
    end

    // completed RAM writes: {adr, sel, dat}
    logic [67:0] log0[$], log1[$];
    always @(negedge clk) begin
        if (!rst && m_cyc0 && m_we0 && ack0) log0.push_back({m_adr0, m_sel0, m_dat0});
        if (!rst && m_cyc1 && m_we1 && ack1) log1.push_back({m_adr1, m_sel1, m_dat1});
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic wait_ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask

    task automatic do_reset();
        rst = 1; cpu_cyc = 0; cpu_we = 0; rx_done = 0; clr_ovf = 0;
        tick(); tick();
        rst = 0;
        log0.delete(); log1.delete();
    endtask

    task automatic send(input logic [7:0] b);
        rx_dat = b; rx_done = 1;
        tick();
        rx_done = 0;
    endtask

    task automatic cpu_release(input string name);
        int k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (c_ack0) begin k = i; break; end
        end
        chk(name, 32'(k != 0), 1);
        tick();
        cpu_cyc = 0;
    endtask

    logic [67:0] e;
    logic [7:0]  b[9];
    logic [31:0] got_rdt;
    logic        ack_seen;
    int          k;

    initial begin
        do_reset();
        chk("rst_ptr0", ptr0, 32'h00C00000);
        chk("rst_ptr1", ptr1, 32'h00C00000);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_cyc0", 32'(m_cyc0), 0);

        send(8'hA5);
        wait_ticks(8);
        chk("sb_n", 32'(log0.size()), 1);
        e = log0.size() > 0 ? log0[0] : '0;
        chk("sb_adr", e[67:36], 32'h00C00000);
        chk("sb_sel", 32'(e[35:32]), 32'h1);
        chk("sb_dat", e[31:0], 32'hA5A5A5A5);
        chk("sb_ptr", ptr0, 32'h00C00001);
        chk("sb_cnt", 32'(cnt0), 0);

        do_reset();
        for (int i = 1; i <= 5; i++) begin send(8'(i)); wait_ticks(3); end
        wait_ticks(6);
        chk("lw_n", 32'(log0.size()), 5);
        for (int i = 0; i < 5 && i < log0.size(); i++) begin
            e = log0[i];
            chk("lw_sel", 32'(e[35:32]), 32'(4'b0001 << (i % 4)));
            chk("lw_byte", 32'(e[7:0]), 32'(i + 1));
        end
        chk("lw_ptr", ptr0, 32'h00C00005);

        do_reset();
        for (int i = 1; i <= 6; i++) begin send(8'(i)); wait_ticks(3); end
        wait_ticks(6);
        chk("wr_n", 32'(log1.size()), 6);
        e = log1.size() > 4 ? log1[4] : '0;
        chk("wr_adr5", e[67:36], 32'h00C00000);
        chk("wr_byte5", 32'(e[7:0]), 32'h05);
        chk("wr_ptr", ptr1, 32'h00C00002);

        do_reset();
        cpu_adr = 32'h10; cpu_we = 0; cpu_sel = 4'hF; cpu_cyc = 1;
        rx_dat = 8'h3C; rx_done = 1;
        tick();
        rx_done = 0;
        k = 0; got_rdt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (c_ack0) begin k = i; got_rdt = c_rdt0; break; end
        end
        chk("ct_ack_lat", 32'(k), 2);
        chk("ct_rdt", got_rdt, 32'hDEADBEFF);
        chk("ct_no_dma", 32'(log0.size()), 0);
        tick();
        cpu_cyc = 0;
        k = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (m_cyc0 && m_we0) begin k = i; break; end
        end
        chk("ct_dma_lat", 32'(k), 2);
        tick();
        wait_ticks(4);
        e = log0.size() > 0 ? log0[0] : '0;
        chk("ct_dma_dat", e[31:0], 32'h3C3C3C3C);

        do_reset();
        cpu_adr = 0; cpu_we = 0; cpu_cyc = 1;
        for (int i = 0; i < 9; i++) begin b[i] = 8'($urandom); send(b[i]); end
        wait_ticks(2);
        chk("ov_cnt", 32'(cnt0), 8);
        chk("ov_flag", 32'(ovf0), 1);
        cpu_release("ov_cpu_ack");
        wait_ticks(40);
        chk("ov_n", 32'(log0.size()), 8);
        for (int i = 0; i < 8 && i < log0.size(); i++) begin
            e = log0[i];
            chk("ov_byte", 32'(e[7:0]), 32'(b[i]));
        end
        chk("ov_still", 32'(ovf0), 1);
        clr_ovf = 1; tick(); clr_ovf = 0;
        chk("ov_clr", 32'(ovf0), 0);

        do_reset();
        send(8'h77);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (m_cyc0 && m_we0) break;
        end
        chk("mr_in_dma", 32'(m_cyc0), 1);
        #2 rst = 1;
        #1;
        chk("mr_cyc", 32'(m_cyc0), 0);
        chk("mr_ptr", ptr0, 32'h00C00000);
        chk("mr_cnt", 32'(cnt0), 0);
        tick();
        rst = 0;

        ack_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            rx_done = (c < 1500) ? ($urandom % 4 == 0) : ($urandom % 2 == 0);
            rx_dat  = 8'($urandom);
            clr_ovf = ($urandom % 40 == 0);
            if (cpu_cyc) begin
                if (ack_seen) cpu_cyc = 0;
            end else if ($urandom % 3 == 0) begin
                cpu_cyc = 1; cpu_we = 1'($urandom); cpu_adr = $urandom;
                cpu_dat = $urandom; cpu_sel = 4'($urandom);
            end
            @(negedge clk);
            ack_seen = c_ack0;
            tick();
        end
        rx_done = 0; clr_ovf = 0;
        wait_ticks(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ble_rx_dma.md
# ble_rx_dma

Receive-side DMA stage between the BLE `uart_rx` and `servant_ram`. It buffers received bytes in a small FIFO and writes each byte into a circular RAM region `[ADR_LL, ADR_UL)`. It also arbitrates the single RAM Wishbone port between the CPU (servant) and its own write engine. It replaces the ad-hoc combinational/registered mux that currently injects `rx_done` bytes into the RAM path, which drops bytes and corrupts CPU cycles.

## Interface
Parameters:
- `BITS`, 8: received byte width. Must be 8.
- `FIFO_DEPTH`, 8: byte FIFO entries. Power of 2, at least 2.
- `ADR_LL`, 32'h00C00000: ring base byte address. Inclusive.
- `ADR_UL`, 32'h00C10000: ring limit byte address. Exclusive. Requires `ADR_UL > ADR_LL`.

Ports:
- `i_wb_clk` in 1: sole clock, rising edge.
- `i_wb_rst` in 1: reset, asynchronous, active-high.
- `i_rx_dat` in BITS: received byte. Valid when `i_rx_done` is high.
- `i_rx_done` in 1: one-cycle strobe from `uart_rx`.
- `i_clr_ovf` in 1: synchronous clear of `o_overflow`.
- `i_wb_cpu_adr` in 32: CPU Wishbone address.
- `i_wb_cpu_dat` in 32: CPU Wishbone write data.
- `i_wb_cpu_sel` in 4: CPU Wishbone byte select.
- `i_wb_cpu_we` in 1: CPU Wishbone write enable.
- `i_wb_cpu_cyc` in 1: CPU Wishbone cycle.
- `o_wb_cpu_rdt` out 32: read data returned to the CPU.
- `o_wb_cpu_ack` out 1: acknowledge returned to the CPU.
- `o_wb_mem_adr` out 32: address to RAM.
- `o_wb_mem_dat` out 32: write data to RAM.
- `o_wb_mem_sel` out 4: byte select to RAM.
- `o_wb_mem_we` out 1: write enable to RAM.
- `o_wb_mem_cyc` out 1: cycle to RAM.
- `i_wb_mem_rdt` in 32: read data from RAM.
- `i_wb_mem_ack` in 1: acknowledge from RAM.
- `o_wr_ptr` out 32: byte address of the next DMA write.
- `o_count` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `o_overflow` out 1: sticky flag, set when a byte is dropped.

## Operation
- **FIFO push.** Occurs on `i_rx_done` when `o_count < FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `o_overflow` is set.
  - `o_overflow` stays set until `i_clr_ovf` or reset. A set and a clear in the same cycle: set wins.
- **Arbiter FSM:** states IDLE, CPU, DMA.
  - **IDLE.**
    - Mem outputs: `cyc=0`, `we=0`, `sel=0`, `adr=0`, `dat=0`.
    - Next state: CPU if `i_wb_cpu_cyc`; else DMA if FIFO is non-empty; else stay in IDLE. CPU has priority.
  - **CPU.**
    - Mem outputs equal the CPU inputs.
    - `o_wb_cpu_ack = i_wb_mem_ack`.
    - On `i_wb_mem_ack`, go to IDLE.
  - **DMA.**
    - `o_wb_mem_cyc=1`, `we=1`, `adr=o_wr_ptr`.
    - `sel = 4'b0001 << o_wr_ptr[1:0]`.
    - `dat` = FIFO head byte replicated to all 4 lanes.
    - On `i_wb_mem_ack`: pop the FIFO, advance `o_wr_ptr`, go to IDLE.
- **CPU ack gating.** `o_wb_cpu_ack` is 0 in every state except CPU. If the CPU raises `cyc` while in DMA, it waits.
- **Read data.** `o_wb_cpu_rdt = i_wb_mem_rdt` combinationally in all states.
- **Pointer advance.** `o_wr_ptr` becomes `o_wr_ptr + 1`. If `o_wr_ptr == ADR_UL-1`, the next value is `ADR_LL` (wrap). Arithmetic is 32-bit unsigned.
- **Simultaneous push and pop.** Both happen. `o_count` is unchanged.

## Timing
- **Reset values** (asynchronous, immediate on `i_wb_rst`):
  - state IDLE; all `o_wb_mem_*` 0; `o_wb_cpu_ack` 0.
  - FIFO empty; `o_count` 0; `o_overflow` 0; `o_wr_ptr = ADR_LL`.
  - Reset in the middle of a CPU or DMA cycle drops `cyc` immediately. The in-flight byte is lost.
- **CPU latency.** One added cycle: `cyc` rises at edge N, state becomes CPU at N+1, and the RAM sees `cyc` from N+1. With `servant_ram`, which acks one cycle after `cyc`, `o_wb_cpu_ack` is asserted at N+2.
- **DMA write.** IDLE→DMA takes 1 cycle. The RAM acks 1 cycle later. Then 1 cycle back to IDLE. Sustained rate is one byte per 3 cycles, far above the UART byte rate.
- **Starvation.** None. Servant drops `cyc` for at least one cycle after an ack, which gives DMA a slot.
- **Count update.** `o_count` and `o_wr_ptr` update on the edge where the ack is sampled.

## Test plan
- **Single byte.** Reset, then `i_rx_dat=8'hA5` with one `i_rx_done` pulse, CPU idle → one DMA write with `adr=32'h00C00000`, `sel=4'b0001`, `dat=32'hA5A5A5A5`. Afterwards `o_wr_ptr=32'h00C00001` and `o_count=0`.
- **Lane walk.** Five bytes 01..05 → `sel` sequence 0001, 0010, 0100, 1000, 0001. Final `o_wr_ptr=32'h00C00005`.
- **Wrap.** With `ADR_UL=ADR_LL+4`, write 6 bytes → the fifth byte goes to `ADR_LL`. Final `o_wr_ptr=ADR_LL+2`.
- **Contention.** CPU read of `32'h00000010` and an `i_rx_done` pulse in the same cycle → CPU is served first and gets its ack. DMA follows within 2 cycles. CPU read data is unaffected.
- **Overflow.** Hold the CPU `cyc` continuously, send 9 bytes with depth 8 → `o_count=8` and `o_overflow=1`. Release the CPU → the 8 bytes are written in order and the 9th is absent. `i_clr_ovf` clears the flag.
- **Mid-DMA reset.** Assert `i_wb_rst` while in DMA → `o_wb_mem_cyc=0` in the same cycle, `o_wr_ptr=ADR_LL`, `o_count=0`.
